// File: rtl/exc_ctrl.sv
// MEM-stage exception controller: CP0 forwarding, interrupt sync,
// event prioritisation, flush/redirect and post-flush recovery.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic        syscall_i,
  input  logic        eret_i,
  input  logic        inst_invalid_i,
  input  logic        trap_i,
  input  logic        ov_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [5:0]  int_sync_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [3:0] RC = 4'(RECOVER_CYCLES);

  typedef enum logic {
    IDLE,
    RECOVER
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        eret_blk;
  logic [5:0]  int_meta;
  logic [5:0]  int_sync;
  logic [31:0] status_eff;
  logic [31:0] cause_eff;
  logic [31:0] epc_eff;
  logic        int_req;
  logic [31:0] exc_code;
  logic        flush;
  logic        unused_ok;

  // Cause forwarding only replaces the software-writable IP/WP/IV fields
  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        5'd12: status_eff = wb_cp0_data_i;
        5'd13: begin
          cause_eff[9:8]   = wb_cp0_data_i[9:8];
          cause_eff[23:22] = wb_cp0_data_i[23:22];
        end
        5'd14: epc_eff = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

  assign unused_ok = ^{status_eff[31:16], status_eff[7:2],
                       cause_eff[31:16], cause_eff[7:0]};

  assign int_req = status_eff[0] & ~status_eff[1]
                 & (|(cause_eff[15:8] & status_eff[15:8]))
                 & ~eret_blk;

  always_comb begin
    exc_code = 32'h0;
    if (!rst && state == IDLE && inst_valid_i) begin
      if (int_req)             exc_code = 32'h1;
      else if (inst_invalid_i) exc_code = 32'ha;
      else if (syscall_i)      exc_code = 32'h8;
      else if (trap_i)         exc_code = 32'hd;
      else if (ov_i)           exc_code = 32'hc;
      else if (eret_i)         exc_code = 32'he;
    end
  end

  assign flush = (exc_code != 32'h0);

  assign excepttype_o        = exc_code;
  assign flush_o             = flush;
  assign current_inst_addr_o = flush ? inst_addr_i : 32'h0;
  assign is_in_delayslot_o   = flush & in_delayslot_i;
  assign int_sync_o          = int_sync;

  always_comb begin
    new_pc_o = 32'h0;
    if (exc_code == 32'he) new_pc_o = epc_eff;
    else if (flush)        new_pc_o = EXC_VECTOR;
  end

  // eret_blk survives RECOVER and covers the first IDLE cycle after eret
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      eret_blk <= 1'b0;
      int_meta <= 6'd0;
      int_sync <= 6'd0;
    end else begin
      int_meta <= int_i;
      int_sync <= int_meta;
      case (state)
        IDLE: begin
          if (flush) begin
            state    <= RECOVER;
            cnt      <= RC;
            eret_blk <= (exc_code == 32'he);
          end else begin
            eret_blk <= 1'b0;
          end
        end
        RECOVER: begin
          if (cnt <= 4'd1) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: default instance plus a
// RECOVER_CYCLES=1 instance for the post-eret interrupt block.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic        dslot;
  logic        syscall, eret, invalid, trap, ov;
  logic [31:0] status, cause, epc;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  logic [31:0] d_exc, d_cur, d_npc;
  logic        d_ds, d_flush;
  logic [5:0]  d_sync;
  logic [31:0] e_exc, e_cur, e_npc;
  logic        e_ds, e_flush;
  logic [5:0]  e_sync;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .int_i(int_i),
    .inst_valid_i(inst_valid), .inst_addr_i(inst_addr),
    .in_delayslot_i(dslot), .syscall_i(syscall), .eret_i(eret),
    .inst_invalid_i(invalid), .trap_i(trap), .ov_i(ov),
    .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
    .wb_cp0_we_i(we), .wb_cp0_waddr_i(waddr), .wb_cp0_data_i(wdata),
    .excepttype_o(d_exc), .current_inst_addr_o(d_cur),
    .is_in_delayslot_o(d_ds), .int_sync_o(d_sync),
    .flush_o(d_flush), .new_pc_o(d_npc)
  );

  exc_ctrl #(.RECOVER_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .int_i(int_i),
    .inst_valid_i(inst_valid), .inst_addr_i(inst_addr),
    .in_delayslot_i(dslot), .syscall_i(syscall), .eret_i(eret),
    .inst_invalid_i(invalid), .trap_i(trap), .ov_i(ov),
    .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc),
    .wb_cp0_we_i(we), .wb_cp0_waddr_i(waddr), .wb_cp0_data_i(wdata),
    .excepttype_o(e_exc), .current_inst_addr_o(e_cur),
    .is_in_delayslot_o(e_ds), .int_sync_o(e_sync),
    .flush_o(e_flush), .new_pc_o(e_npc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wait();
    inst_valid = 0; syscall = 0; eret = 0; invalid = 0;
    trap = 0; ov = 0; dslot = 0; we = 0; waddr = 0; wdata = 0;
    status = 0; cause = 0; epc = 0; int_i = 0;
    repeat (4) step();
  endtask

  initial begin
    rst = 1; int_i = 0; inst_valid = 1; inst_addr = 32'h100;
    dslot = 0; syscall = 1; eret = 0; invalid = 0; trap = 0; ov = 0;
    status = 0; cause = 0; epc = 0; we = 0; waddr = 0; wdata = 0;
    #2;
    chk("rst_exc", d_exc, 32'h0);
    chk("rst_flush", {31'b0, d_flush}, 32'h0);
    chk("rst_npc", d_npc, 32'h0);
    chk("rst_cur", d_cur, 32'h0);
    chk("rst_sync", {26'b0, d_sync}, 32'h0);

    step(); rst = 0; #1;
    chk("sys_exc", d_exc, 32'h8);
    chk("sys_flush", {31'b0, d_flush}, 32'h1);
    chk("sys_npc", d_npc, 32'h20);
    chk("sys_cur", d_cur, 32'h100);
    step();
    chk("rec1_exc", d_exc, 32'h0);
    chk("rec1_flush", {31'b0, d_flush}, 32'h0);
    step();
    chk("rec2_exc", d_exc, 32'h0);
    step();
    chk("sys_again", d_exc, 32'h8);

    step();
    chk("rec_before_rst", {31'b0, d_flush}, 32'h0);
    rst = 1; #1;
    chk("rst_mid_flush", {31'b0, d_flush}, 32'h0);
    rst = 0; #1;
    chk("rst_to_idle", d_exc, 32'h8);
    clear_wait();

    inst_valid = 1; inst_addr = 32'h180;
    ov = 1; trap = 1; invalid = 1; #1;
    chk("prio_inv", d_exc, 32'ha);
    chk("prio_inv_npc", d_npc, 32'h20);
    clear_wait();

    inst_valid = 1; inst_addr = 32'h200; dslot = 1;
    ov = 1; trap = 1; invalid = 1;
    status = 32'h0000_0401; cause = 32'h0000_0400; #1;
    chk("prio_int", d_exc, 32'h1);
    chk("prio_int_ds", {31'b0, d_ds}, 32'h1);
    chk("prio_int_cur", d_cur, 32'h200);
    chk("prio_int_npc", d_npc, 32'h20);
    clear_wait();

    int_i = 6'b000001;
    step(); int_i = 0;
    chk("sync_lat1", {26'b0, d_sync}, 32'h0);
    step();
    chk("sync_lat2", {26'b0, d_sync}, 32'h1);
    step();
    chk("sync_fall", {26'b0, d_sync}, 32'h0);

    inst_valid = 1; status = 32'h0000_0403; cause = 32'h0000_0400; #1;
    chk("exl_mask", d_exc, 32'h0);
    chk("exl_mask_flush", {31'b0, d_flush}, 32'h0);
    inst_valid = 0; status = 32'h0000_0401; #1;
    chk("invalid_slot", d_exc, 32'h0);
    clear_wait();

    inst_valid = 1; eret = 1; epc = 32'h40;
    we = 1; waddr = 5'd14; wdata = 32'h80; #1;
    chk("fwd_epc_exc", d_exc, 32'he);
    chk("fwd_epc_npc", d_npc, 32'h80);
    clear_wait();

    inst_valid = 1; status = 32'h0000_0401; cause = 32'h0000_0400;
    we = 1; waddr = 5'd12; wdata = 32'h0000_0400; #1;
    chk("fwd_status_off", d_exc, 32'h0);
    we = 0; #1;
    chk("fwd_status_ctl", d_exc, 32'h1);
    clear_wait();

    inst_valid = 1; status = 32'h0000_0101; cause = 32'h0;
    we = 1; waddr = 5'd13; wdata = 32'h0000_0100; #1;
    chk("fwd_cause", d_exc, 32'h1);
    clear_wait();

    rst = 1; #1; rst = 0; #1;
    inst_valid = 1; eret = 1; epc = 32'h300; #1;
    chk("eb_exc", e_exc, 32'he);
    chk("eb_npc", e_npc, 32'h300);
    step();
    eret = 0; status = 32'h0000_0401; cause = 32'h0000_0400; #1;
    chk("eb_recover", e_exc, 32'h0);
    step();
    chk("eb_blocked", e_exc, 32'h0);
    chk("eb_blocked_fl", {31'b0, e_flush}, 32'h0);
    step();
    chk("eb_taken", e_exc, 32'h1);
    clear_wait();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- MEM-stage exception controller. Produces the `excepttype_i`, `current_inst_addr_i` and `is_in_delayslot_i` inputs of the CP0 register file.
- Consumes the Status, Cause and EPC register values, forwarding any CP0 write still pending in WB.
- Synchronises external interrupt lines, prioritises interrupts and exceptions, and drives the pipeline flush and redirect PC.
- Runs a short recovery FSM that masks new events for a fixed window after each flush.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect PC for every exception except eret.
- RECOVER_CYCLES, 2, cycles after a flush during which new exceptions and interrupts are masked (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- int_i  in  6  raw external hardware interrupts, asynchronous
- inst_valid_i  in  1  MEM stage holds a real instruction
- inst_addr_i  in  32  PC of the MEM-stage instruction
- in_delayslot_i  in  1  MEM instruction sits in a branch delay slot
- syscall_i, eret_i, inst_invalid_i, trap_i, ov_i  in  1 each  exception flags from MEM
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  CP0 register outputs
- wb_cp0_we_i  in  1  CP0 write pending in WB
- wb_cp0_waddr_i  in  5  CP0 write address (12 Status, 13 Cause, 14 EPC)
- wb_cp0_data_i  in  32  CP0 write data
- excepttype_o  out  32  exception code to CP0
- current_inst_addr_o  out  32  PC to CP0
- is_in_delayslot_o  out  1  delay-slot flag to CP0
- int_sync_o  out  6  synchronised interrupt lines, routed to CP0 `int_i`
- flush_o  out  1  flush all pipeline stages
- new_pc_o  out  32  redirect target, valid while `flush_o`=1

Behaviour:
- Reset: one clock, `clk`. Reset `rst` is asynchronous and active-high. While reset is asserted:
  - sync flops are 0, FSM is IDLE, recovery counter is 0;
  - all outputs are 0.
- Interrupt synchronisation: two-flop synchroniser per `int_i` bit. `int_sync_o` is the second stage, so latency is 2 cycles.
- CP0 forwarding (combinational), applied when `wb_cp0_we_i`=1:
  - addr 12: effective Status = `wb_cp0_data_i`;
  - addr 13: effective Cause = `cp0_cause_i` with bits [9:8] and [23:22] taken from write data;
  - addr 14: effective EPC = `wb_cp0_data_i`;
  - otherwise the CP0 input is used unchanged.
- Interrupt condition `int_req` = Status[0] & ~Status[1] & (|(Cause[15:8] & Status[15:8])), all on effective values.
- Decision, combinational, evaluated only in IDLE with `inst_valid_i`=1. Priority high→low, `excepttype_o` value:
  - `int_req` → 1
  - `inst_invalid_i` → 0xa
  - `syscall_i` → 0x8
  - `trap_i` → 0xd
  - `ov_i` → 0xc
  - `eret_i` → 0xe
  - none → 0
- Output drive:
  - In RECOVER, or when `inst_valid_i`=0, `excepttype_o`=0.
  - `current_inst_addr_o` = `inst_addr_i` and `is_in_delayslot_o` = `in_delayslot_i` whenever `excepttype_o`≠0; both are 0 otherwise.
- Flush:
  - `flush_o`=1 in the same cycle `excepttype_o`≠0.
  - `new_pc_o` = effective EPC for 0xe, `EXC_VECTOR` for all other codes, and 0 when not flushing.
- FSM:
  - IDLE → RECOVER on any nonzero `excepttype_o`; counter loads `RECOVER_CYCLES`.
  - RECOVER: counter decrements each cycle; → IDLE when it reaches 1.
- Eret block: in the cycle after an eret flush, `int_req` is additionally masked, even if `RECOVER_CYCLES` has expired.
- Simultaneous events: only the highest priority is reported. Lower-priority flags in the same cycle are dropped, not queued.
- Reset mid-RECOVER: returns to IDLE immediately.

Test Plan:
- Reset: assert `rst` asynchronously mid-cycle with `syscall_i`=1 → all outputs 0 at once; FSM IDLE after release.
- Syscall: `inst_valid_i`=1, `syscall_i`=1, `inst_addr_i`=0x100 → `excepttype_o`=0x8, `flush_o`=1, `new_pc_o`=0x20, `current_inst_addr_o`=0x100. Flags held for the next 2 cycles → outputs 0 (RECOVER). Cycle 3 → reported again.
- Priority: `ov_i`=`trap_i`=`inst_invalid_i`=1 → 0xa. Same again with `int_req` true → 1; `is_in_delayslot_o` follows `in_delayslot_i`=1.
- Interrupt sync: Status=0x0000_0401, Cause[10]=1, `int_i`[0] pulsed → `int_sync_o`[0] rises 2 cycles later. Setting Status[1]=1 → no interrupt taken.
- Forwarding: `cp0_epc_i`=0x40, WB writes EPC=0x80, `eret_i`=1 → `new_pc_o`=0x80, `excepttype_o`=0xe. WB write to Status setting IE=0 in the same cycle as a pending interrupt → interrupt not taken.
- Eret block: eret, then `int_req` true on the first cycle after RECOVER with `RECOVER_CYCLES`=1 → masked one cycle, taken the next.
